// File: rtl/reg_access_master.sv
// Register-bank access master: accepts one command at a time (write, read or
// burst read), sequences the bank strobes, and returns read bytes over a
// valid/ready response channel. Blocked bank accesses are bounded by a stall
// counter that aborts the command and raises a sticky error.
module reg_access_master #(
  parameter logic [7:0] STALL_LIMIT = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  // Command channel
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_addr,
  input  logic [7:0] cmd_data,
  // Register bank
  output logic [4:0] mem_addr,
  output logic       mem_addr_update,
  output logic       mem_wren,
  output logic [7:0] mem_wdata,
  input  logic       mem_full,
  output logic       mem_rden,
  input  logic [7:0] mem_rdata,
  input  logic       mem_empty,
  // Response channel
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [4:0] rsp_addr,
  output logic       rsp_last,
  // Status
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWrite,
    StRead,
    StCapture,
    StResp
  } state_e;

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpBurst = 2'b10;
  localparam logic [1:0] OpIllegal = 2'b11;

  state_e     state_q;
  logic [1:0] op_q;
  logic [4:0] rem_q;
  logic [7:0] stall_q;
  logic [4:0] mem_addr_q;
  logic       mem_addr_update_q;
  logic [7:0] mem_wdata_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic [4:0] rsp_addr_q;
  logic       rsp_last_q;
  logic       err_q;

  // Sequencer: command latch, address stepping, stall bound and response capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      op_q              <= 2'b00;
      rem_q             <= 5'd0;
      stall_q           <= 8'd0;
      mem_addr_q        <= 5'd0;
      mem_addr_update_q <= 1'b0;
      mem_wdata_q       <= 8'd0;
      rsp_valid_q       <= 1'b0;
      rsp_data_q        <= 8'd0;
      rsp_addr_q        <= 5'd0;
      rsp_last_q        <= 1'b0;
      err_q             <= 1'b0;
    end else begin
      mem_addr_update_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_op == OpIllegal) begin
              err_q <= 1'b1;
            end else begin
              op_q              <= cmd_op;
              mem_addr_q        <= cmd_addr;
              mem_addr_update_q <= 1'b1;
              rem_q             <= (cmd_op == OpBurst) ? cmd_data[4:0] : 5'd0;
              if (cmd_op == OpWrite) begin
                mem_wdata_q <= cmd_data;
              end
              state_q <= StAddr;
            end
          end
        end
        StAddr: begin
          stall_q <= 8'd0;
          state_q <= (op_q == OpWrite) ? StWrite : StRead;
        end
        StWrite: begin
          if (!mem_full) begin
            stall_q <= 8'd0;
            state_q <= StIdle;
          end else if (stall_q + 8'd1 == STALL_LIMIT) begin
            // Bank stayed full too long: drop the command.
            stall_q <= 8'd0;
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            stall_q <= stall_q + 8'd1;
          end
        end
        StRead: begin
          if (!mem_empty) begin
            stall_q <= 8'd0;
            state_q <= StCapture;
          end else if (stall_q + 8'd1 == STALL_LIMIT) begin
            // Abandon the remaining burst beats too.
            stall_q <= 8'd0;
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            stall_q <= stall_q + 8'd1;
          end
        end
        StCapture: begin
          rsp_data_q  <= mem_rdata;
          rsp_addr_q  <= mem_addr_q;
          rsp_last_q  <= (rem_q == 5'd0);
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (rem_q == 5'd0) begin
              state_q <= StIdle;
            end else begin
              rem_q             <= rem_q - 5'd1;
              mem_addr_q        <= mem_addr_q + 5'd1;  // 5-bit add wraps 31 -> 0
              mem_addr_update_q <= 1'b1;
              state_q           <= StAddr;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes must react to mem_full/mem_empty in the same cycle, so they are
  // decoded from the state register rather than registered themselves.
  always_comb begin
    mem_wren = (state_q == StWrite) && !mem_full;
    mem_rden = (state_q == StRead) && !mem_empty;
  end

  // Status and registered outputs.
  always_comb begin
    cmd_ready       = (state_q == StIdle);
    busy            = (state_q != StIdle);
    mem_addr        = mem_addr_q;
    mem_addr_update = mem_addr_update_q;
    mem_wdata       = mem_wdata_q;
    rsp_valid       = rsp_valid_q;
    rsp_data        = rsp_data_q;
    rsp_addr        = rsp_addr_q;
    rsp_last        = rsp_last_q;
    err             = err_q;
  end

endmodule

// File: tb/tb_reg_access_master.sv
// Directed bench for reg_access_master: a table of single commands plus
// hand-written burst, stall/abort and reset-during-response sequences.
module tb_reg_access_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [4:0] mem_addr;
  logic       mem_addr_update;
  logic       mem_wren;
  logic [7:0] mem_wdata;
  logic       mem_full;
  logic       mem_rden;
  logic [7:0] mem_rdata;
  logic       mem_empty;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [4:0] rsp_addr;
  logic       rsp_last;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [7:0] bank [32];

  reg_access_master #(.STALL_LIMIT(8'd4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_addr        (cmd_addr),
    .cmd_data        (cmd_data),
    .mem_addr        (mem_addr),
    .mem_addr_update (mem_addr_update),
    .mem_wren        (mem_wren),
    .mem_wdata       (mem_wdata),
    .mem_full        (mem_full),
    .mem_rden        (mem_rden),
    .mem_rdata       (mem_rdata),
    .mem_empty       (mem_empty),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_addr        (rsp_addr),
    .rsp_last        (rsp_last),
    .busy            (busy),
    .err             (err)
  );

  always #5 clk = ~clk;

  // 32x8 bank model: read data appears one cycle after mem_rden.
  always @(posedge clk) begin
    if (mem_wren) bank[mem_addr] <= mem_wdata;
    if (mem_rden) mem_rdata <= bank[mem_addr];
  end

  // Strobes are mutually exclusive and only occur while busy.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((mem_wren && mem_rden) || (!busy && (mem_wren || mem_rden))) begin
        errors++;
        $display("FAIL strobe_rule: wren=%0b rden=%0b busy=%0b required no overlap and none idle",
                 mem_wren, mem_rden, busy);
      end
    end
  end

  typedef struct {
    logic [1:0] op;
    logic [4:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_addr_update"}, mem_addr_update, 0);
    chk({tag, "_wren"}, mem_wren, 0);
    chk({tag, "_rden"}, mem_rden, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_addr"}, rsp_addr, 0);
    chk({tag, "_rsp_last"}, rsp_last, 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 5'd0;
    cmd_data  = 8'd0;
    rsp_ready = 1'b0;
    mem_full  = 1'b0;
    mem_empty = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] addr, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
  endtask

  // One command from the table, checked cycle by cycle from accept.
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    issue(v.op, v.addr, v.data);
    if (v.op == 2'b11) begin
      chk({t, "_ill_ready"}, cmd_ready, 1);
      chk({t, "_ill_err"}, err, 1);
      chk({t, "_ill_busy"}, busy, 0);
      chk({t, "_ill_update"}, mem_addr_update, 0);
    end else begin
      chk({t, "_update"}, mem_addr_update, 1);
      chk({t, "_addr"}, mem_addr, v.addr);
      chk({t, "_busy"}, busy, 1);
      chk({t, "_ready_low"}, cmd_ready, 0);
      step();
      if (v.op == 2'b00) begin
        chk({t, "_wren"}, mem_wren, 1);
        chk({t, "_wdata"}, mem_wdata, v.data);
        chk({t, "_waddr"}, mem_addr, v.addr);
        step();
        chk({t, "_wren_off"}, mem_wren, 0);
        chk({t, "_w_idle"}, cmd_ready, 1);
        chk({t, "_w_norsp"}, rsp_valid, 0);
      end else begin
        chk({t, "_rden"}, mem_rden, 1);
        chk({t, "_update_off"}, mem_addr_update, 0);
        step();
        chk({t, "_rden_off"}, mem_rden, 0);
        chk({t, "_rsp_early"}, rsp_valid, 0);
        step();
        for (int k = 0; k < 3; k++) begin
          chk({t, "_rsp_valid"}, rsp_valid, 1);
          chk({t, "_rsp_data"}, rsp_data, v.exp_rdata);
          chk({t, "_rsp_addr"}, rsp_addr, v.addr);
          chk({t, "_rsp_last"}, rsp_last, 1);
          if (k < 2) step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({t, "_rsp_done"}, rsp_valid, 0);
        chk({t, "_r_idle"}, cmd_ready, 1);
      end
    end
  endtask

  initial begin
    logic [7:0] r_data [3];
    logic [4:0] r_addr [3];
    logic       r_last [3];
    int         nresp;
    int         upd;
    bit         seen;

    for (int i = 0; i < 32; i++) bank[i] = 8'h00;
    bank[3]  = 8'hC3;
    bank[14] = 8'hB9;
    bank[30] = 8'h5A;
    bank[31] = 8'hE1;
    bank[0]  = 8'h3C;
    mem_rdata = 8'h00;

    vecs[0] = '{2'b00, 5'd1,  8'h02, 8'h00};
    vecs[1] = '{2'b01, 5'd14, 8'h00, 8'hB9};
    vecs[2] = '{2'b00, 5'd7,  8'h77, 8'h00};
    vecs[3] = '{2'b01, 5'd7,  8'hFF, 8'h77};
    vecs[4] = '{2'b00, 5'd20, 8'hA4, 8'h00};
    vecs[5] = '{2'b01, 5'd20, 8'h00, 8'hA4};
    vecs[6] = '{2'b11, 5'd9,  8'h33, 8'h00};

    // Reset state
    do_reset();
    mon_en = 1'b1;
    chk_reset_vals("rst");

    // Single commands; illegal op last since err is sticky
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Burst read wrapping 30 -> 31 -> 0
    do_reset();
    rsp_ready = 1'b1;
    issue(2'b10, 5'd30, 8'd2);
    nresp = 0;
    upd   = 0;
    for (int c = 0; c < 40; c++) begin
      if (mem_addr_update) upd++;
      if (rsp_valid) begin
        if (nresp < 3) begin
          r_data[nresp] = rsp_data;
          r_addr[nresp] = rsp_addr;
          r_last[nresp] = rsp_last;
        end
        nresp++;
      end
      if (nresp >= 3 && cmd_ready) break;
      step();
    end
    rsp_ready = 1'b0;
    chk("burst_done", cmd_ready, 1);
    chk("burst_nresp", nresp, 3);
    chk("burst_updates", upd, 3);
    chk("burst_addr0", r_addr[0], 30);
    chk("burst_addr1", r_addr[1], 31);
    chk("burst_addr2", r_addr[2], 0);
    chk("burst_data0", r_data[0], 8'h5A);
    chk("burst_data1", r_data[1], 8'hE1);
    chk("burst_data2", r_data[2], 8'h3C);
    chk("burst_last0", r_last[0], 0);
    chk("burst_last1", r_last[1], 0);
    chk("burst_last2", r_last[2], 1);
    chk("burst_err", err, 0);

    // Write stalled by mem_full until the limit of 4 blocked cycles
    mem_full = 1'b1;
    issue(2'b00, 5'd5, 8'h55);
    chk("stall_update", mem_addr_update, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("stall_wren_%0d", k), mem_wren, 0);
      chk($sformatf("stall_busy_%0d", k), busy, 1);
      chk($sformatf("stall_err_%0d", k), err, 0);
    end
    step();
    chk("stall_err_set", err, 1);
    chk("stall_ready", cmd_ready, 1);
    chk("stall_norsp", rsp_valid, 0);
    mem_full = 1'b0;
    run_vec('{2'b00, 5'd5, 8'h66, 8'h00}, 10);
    chk("stall_err_sticky", err, 1);

    // Read held off by mem_empty for two cycles
    mem_empty = 1'b1;
    issue(2'b01, 5'd14, 8'h00);
    step();
    chk("empty_rden0", mem_rden, 0);
    step();
    chk("empty_rden1", mem_rden, 0);
    mem_empty = 1'b0;
    #1;
    chk("empty_rden_go", mem_rden, 1);
    step();
    chk("empty_capture", rsp_valid, 0);
    step();
    chk("empty_rsp_valid", rsp_valid, 1);
    chk("empty_rsp_data", rsp_data, 8'hB9);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("empty_idle", cmd_ready, 1);

    // Reset while a burst response is pending
    do_reset();
    issue(2'b10, 5'd3, 8'd5);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("rr_seen", seen, 1);
    chk("rr_rsp_addr", rsp_addr, 3);
    chk("rr_rsp_data", rsp_data, 8'hC3);
    chk("rr_rsp_last", rsp_last, 0);
    rst_n = 1'b0;
    step();
    chk_reset_vals("rr");
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr_quiet_valid_%0d", k), rsp_valid, 0);
      chk($sformatf("rr_quiet_busy_%0d", k), busy, 0);
    end
    run_vec('{2'b01, 5'd14, 8'h00, 8'hB9}, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_access_master.md
REG_ACCESS_MASTER -- requirements
Module: reg_access_master

Interface
REQ-001 Parameter STALL_LIMIT, default 8'd255: max cycles a single mem access may wait on mem_full/mem_empty before abort.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
REQ-006 cmd_op  input  2  00 write, 01 read, 10 burst read, 11 illegal.
REQ-007 cmd_addr  input  5  register address.
REQ-008 cmd_data  input  8  write data (op 00); burst length-1 in [4:0] (op 10); ignored for op 01.
REQ-009 mem_addr  output  5  address to 32x8 register bank.
REQ-010 mem_addr_update  output  1  one-cycle pulse when mem_addr changes.
REQ-011 mem_wren  output  1  write strobe, one cycle per write.
REQ-012 mem_wdata  output  8  write data.
REQ-013 mem_full  input  1  bank cannot accept write this cycle.
REQ-014 mem_rden  output  1  read strobe, one cycle per read.
REQ-015 mem_rdata  input  8  read data, valid exactly one cycle after mem_rden.
REQ-016 mem_empty  input  1  bank cannot serve read this cycle.
REQ-017 rsp_valid / rsp_ready  output / input  1 / 1  read-response handshake.
REQ-018 rsp_data  output  8  read byte; rsp_addr output 5 its address; rsp_last output 1 final byte of command.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 err  output  1  sticky error flag; cleared only by reset.

Function
REQ-021 States: IDLE, ADDR, WRITE, READ, CAPTURE, RESP.
REQ-022 cmd_ready SHALL be 1 only in IDLE; only one command in flight.
REQ-023 IDLE: on accept of op 00/01/10, latch op, addr, data, remaining count (0 for 00/01, cmd_data[4:0] for 10), go ADDR.
REQ-024 IDLE: on accept of op 11, set err, stay IDLE; no mem strobe, no response.
REQ-025 ADDR: drive latched address on mem_addr, pulse mem_addr_update for exactly one cycle, go WRITE (op 00) or READ (op 01/10).
REQ-026 WRITE: assert mem_wren with mem_wdata for one cycle in the first cycle with mem_full=0, then IDLE; writes produce no response.
REQ-027 READ: assert mem_rden for one cycle in the first cycle with mem_empty=0, then CAPTURE.
REQ-028 CAPTURE: register mem_rdata into rsp_data, mem_addr into rsp_addr, rsp_last=(remaining==0); go RESP.
REQ-029 RESP: rsp_valid=1 and rsp_data/rsp_addr/rsp_last stable until rsp_ready=1; on handshake, if remaining==0 go IDLE, else decrement remaining, address+1 modulo 32 (31 wraps to 0), go ADDR.
REQ-030 Minimum latency: accept to mem_rden = 2 cycles; mem_rden to rsp_valid = 2 cycles; accept to mem_wren = 2 cycles.
REQ-031 Stall counter SHALL count consecutive blocked cycles in WRITE/READ; on reaching STALL_LIMIT, set err, abandon the rest of the command, return to IDLE with no strobe and no further response.
REQ-032 mem_wren and mem_rden SHALL never be asserted in the same cycle, and never outside WRITE/READ.
REQ-033 mem_addr SHALL hold its value outside ADDR transitions.

Reset
REQ-034 When rst_n=0 at a clock edge: state IDLE; cmd_ready=1 next cycle; mem_addr=0, mem_wdata=0, rsp_data=0, rsp_addr=0; mem_addr_update, mem_wren, mem_rden, rsp_valid, rsp_last, busy, err = 0; stall counter and remaining = 0.
REQ-035 Reset asserted mid-command (any state, including RESP with rsp_valid=1) SHALL abort it with no further strobe or response.

Verification
REQ-036 Write: op 00, addr 1, data 8'h02, mem_full=0 -> addr_update at cycle 1, mem_wren=1 with addr 1/data 02 at cycle 2, no rsp_valid, IDLE at cycle 3.
REQ-037 Read: op 01, addr 14, bank returns 8'hB9 -> rsp_valid with rsp_data B9, rsp_addr 14, rsp_last 1; held 3 cycles while rsp_ready=0.
REQ-038 Burst wrap: op 10, addr 30, cmd_data 2 -> three responses at addrs 30, 31, 0; rsp_last only on third; three addr_update pulses.
REQ-039 Stall/abort: STALL_LIMIT=4, op 00 with mem_full held 1 -> no mem_wren, err=1 after 4 blocked cycles, cmd_ready=1 next cycle; mem_full then 0 with new write -> write completes, err stays 1.
REQ-040 Illegal op 11 -> err=1, no strobes, cmd_ready stays 1.
REQ-041 Reset during RESP of burst (addr 3, length-1 5) -> rsp_valid=0, all outputs at reset values, next read command behaves as REQ-037.
